// File: rtl/mips_pkg.sv
// mips_pkg -- definitions shared by the fetch stage and its sub-modules.
//   * MIPS primary opcode constants (instr[31:26])
//   * fetch_state_t : fetch FSM encoding (also exported on state_o for debug)
//   * fetch_entry_t : one fetch-buffer entry, {pc, instr}
//   * opcode_of()   : extracts the primary opcode from an instruction word
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    function automatic logic [5:0] opcode_of(input logic [31:0] instr);
        return instr[31:26];
    endfunction

endpackage

// File: rtl/fetch_fifo2.sv
// fetch_fifo2 -- 2-entry synchronous fetch buffer with flush.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   i_flush      : drop all entries (count -> 0); overrides i_enq
//   i_enq        : write i_enq_data (accepted if not full, or full with a dequeue)
//   i_enq_data   : {pc, instr} to store
//   i_deq        : pop the head (ignored when empty)
//   o_valid      : head holds a valid entry
//   o_head       : head entry; holds the last shown head while empty
//   o_count      : number of valid entries (0..2)
module fetch_fifo2
    import mips_pkg::*;
#(
    parameter int FIFO_DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_flush,
    input  logic         i_enq,
    input  fetch_entry_t i_enq_data,
    input  logic         i_deq,
    output logic         o_valid,
    output fetch_entry_t o_head,
    output logic [1:0]   o_count
);

    if (FIFO_DEPTH != 2) begin : g_depth_check
        $error("fetch_fifo2: FIFO_DEPTH must be 2");
    end

    fetch_entry_t r_mem [2];
    fetch_entry_t r_last_head;
    logic         r_rd_ptr;
    logic         r_wr_ptr;
    logic [1:0]   r_count;

    logic w_do_deq;
    logic w_do_enq;

    assign w_do_deq = i_deq && (r_count != 2'd0);
    // A full buffer may still accept a write when the head leaves this cycle.
    assign w_do_enq = i_enq && !i_flush && ((r_count != 2'd2) || w_do_deq);

    // Storage has no reset; a slot is only observed after it has been written.
    for (genvar gi = 0; gi < 2; gi++) begin : g_slot
        always_ff @(posedge clk) begin
            if (w_do_enq && (r_wr_ptr == 1'(gi))) begin
                r_mem[gi] <= i_enq_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr    <= 1'b0;
            r_wr_ptr    <= 1'b0;
            r_count     <= 2'd0;
            r_last_head <= '0;
        end else begin
            // Track the currently shown head so the outputs freeze on it when
            // the buffer empties (by drain or flush) instead of showing stale slots.
            if (r_count != 2'd0) begin
                r_last_head <= r_mem[r_rd_ptr];
            end
            if (i_flush) begin
                r_rd_ptr <= 1'b0;
                r_wr_ptr <= 1'b0;
                r_count  <= 2'd0;
            end else begin
                if (w_do_deq) r_rd_ptr <= ~r_rd_ptr;
                if (w_do_enq) r_wr_ptr <= ~r_wr_ptr;
                case ({w_do_enq, w_do_deq})
                    2'b10:   r_count <= r_count + 2'd1;
                    2'b01:   r_count <= r_count - 2'd1;
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    assign o_valid = (r_count != 2'd0);
    assign o_head  = o_valid ? r_mem[r_rd_ptr] : r_last_head;
    assign o_count = r_count;

endmodule

// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit -- fetch stage in front of inst_memory.
// Owns the word-addressed PC, drives the combinational imem read port and
// buffers {pc, instr} pairs in fetch_fifo2 for decode (valid/ready).
// Ports:
//   clk, rst_n             : clock, asynchronous active-low reset
//   start                  : IDLE -> FETCH (pc = RESET_PC), HALTED -> FETCH (pc kept)
//   halt                   : stop new fetches, buffer keeps draining; beats start
//   imem_addr / imem_data  : combinational instruction memory read port
//   redirect / redirect_pc : taken branch/jump; flush buffer and reload pc
//   out_valid/out_ready    : decode handshake; out_instr/out_pc carry the head
//   state_o                : current FSM state (debug)
// Build option: define INST_FETCH_PREDECODE_EN to follow 'j' instructions in
// fetch (pc <= {6'b0, instr[25:0]}) instead of waiting for a redirect.
module inst_fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'd0,
    parameter int          IMEM_DEPTH = 1024,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        halt,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic [1:0]  state_o
);

    fetch_state_t r_state;
    fetch_state_t w_state_next;
    logic [31:0]  r_pc;
    logic [31:0]  w_pc_next;
    logic [31:0]  w_pc_inc;
    logic [31:0]  w_pc_seq;

    logic         w_fifo_valid;
    logic [1:0]   w_fifo_count;
    fetch_entry_t w_head;
    fetch_entry_t w_enq_data;
    logic         w_deq;
    logic         w_space;
    logic         w_fetch;

    assign w_deq   = w_fifo_valid && out_ready;
    assign w_space = (w_fifo_count != 2'd2) || w_deq;
    // Redirect squashes the fetch of the (now wrong-path) pc this cycle.
    assign w_fetch = (r_state == FETCH) && !redirect && !halt && w_space;

    assign w_pc_inc = (r_pc == 32'(IMEM_DEPTH - 1)) ? 32'd0 : r_pc + 32'd1;

`ifdef INST_FETCH_PREDECODE_EN
    assign w_pc_seq = (opcode_of(imem_data) == OP_J) ? {6'b0, imem_data[25:0]} : w_pc_inc;
`else
    assign w_pc_seq = w_pc_inc;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_pc    <= RESET_PC;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        case (r_state)
            IDLE: begin
                if (start && !halt) begin
                    w_state_next = FETCH;
                    w_pc_next    = RESET_PC;
                end
            end
            FETCH: begin
                if (halt) w_state_next = HALTED;
            end
            HALTED: begin
                if (start && !halt) w_state_next = FETCH;
            end
            default: w_state_next = IDLE;
        endcase
        if (w_fetch)  w_pc_next = w_pc_seq;
        // Redirect loads pc in every state and wins over everything else.
        if (redirect) w_pc_next = redirect_pc;
    end

    assign w_enq_data.pc    = r_pc;
    assign w_enq_data.instr = imem_data;

    fetch_fifo2 #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_flush    (redirect),
        .i_enq      (w_fetch),
        .i_enq_data (w_enq_data),
        .i_deq      (w_deq),
        .o_valid    (w_fifo_valid),
        .o_head     (w_head),
        .o_count    (w_fifo_count)
    );

    assign imem_addr = r_pc;
    assign out_valid = w_fifo_valid;
    assign out_instr = w_head.instr;
    assign out_pc    = w_head.pc;
    assign state_o   = r_state;

endmodule

// File: tb/tb_inst_fetch_unit.sv
module tb_inst_fetch_unit;
    import mips_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic        halt = 1'b0;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [1:0]  state_o;

    logic [31:0] imem [0:1023];
    assign imem_data = (imem_addr < 32'd1024) ? imem[imem_addr[9:0]] : 32'h0;

    always #5 clk = ~clk;

    inst_fetch_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .halt        (halt),
        .imem_addr   (imem_addr),
        .imem_data   (imem_data),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_instr   (out_instr),
        .out_pc      (out_pc),
        .state_o     (state_o)
    );

    int checks = 0;
    int passes = 0;
    logic [31:0] exp_pc_q [$];
    logic [31:0] exp_instr_q [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic push(input logic [31:0] p);
        exp_pc_q.push_back(p);
        exp_instr_q.push_back(imem[p[9:0]]);
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        start = 1'b0; halt = 1'b0; redirect = 1'b0; redirect_pc = 32'd0; out_ready = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(1);
    endtask

    // Monitor: every accepted head is compared against the scoreboard queue.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_pc_q.size() == 0) begin
                checks++;
                $display("FAIL unexpected_handshake: got pc %h expected none", out_pc);
            end else begin
                logic [31:0] ep, ei;
                ep = exp_pc_q.pop_front();
                ei = exp_instr_q.pop_front();
                $display("TXN pc=%h instr=%h (expected pc=%h instr=%h)", out_pc, out_instr, ep, ei);
                chk("hs_pc", out_pc, ep);
                chk("hs_instr", out_instr, ei);
            end
        end
    end

    // Redirect from FETCH to tgt with decode always ready; expectations pushed by caller.
    task automatic redirect_run(input logic [31:0] tgt);
        do_reset();
        out_ready = 1'b1;
        start = 1'b1;
        step(1);
        start = 1'b0;
        redirect = 1'b1;
        redirect_pc = tgt;
        step(1);
        redirect = 1'b0;
        step(5);
        out_ready = 1'b0;
        chk("redir_q_empty", 32'(exp_pc_q.size()), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) imem[i] = {OP_ADDI, 26'(i * 3 + 1)};
        imem[18] = {6'h2, 26'h7};

        // Reset state
        rst_n = 1'b0;
        #3;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_instr", out_instr, 32'd0);
        chk("rst_pc", out_pc, 32'd0);
        chk("rst_state", 32'(state_o), 32'(IDLE));
        chk("rst_addr", imem_addr, 32'd0);

        // Streaming: pcs 0..7 one per cycle
        do_reset();
        for (int i = 0; i < 8; i++) push(32'(i));
        out_ready = 1'b1;
        start = 1'b1;
        step(1);
        start = 1'b0;
        chk("stream_state", 32'(state_o), 32'(FETCH));
        step(9);
        out_ready = 1'b0;
        chk("stream_q_empty", 32'(exp_pc_q.size()), 32'd0);
        chk("stream_next_valid", 32'(out_valid), 32'd1);
        chk("stream_next_pc", out_pc, 32'd8);

        // Backpressure: buffer saturates at 2, pc held at 2
        do_reset();
        start = 1'b1;
        step(1);
        start = 1'b0;
        step(5);
        chk("bp_addr", imem_addr, 32'd2);
        chk("bp_head_pc", out_pc, 32'd0);
        chk("bp_valid", 32'(out_valid), 32'd1);
        for (int i = 0; i < 4; i++) push(32'(i));
        out_ready = 1'b1;
        step(4);
        out_ready = 1'b0;
        chk("bp_q_empty", 32'(exp_pc_q.size()), 32'd0);

        // Redirect while buffer holds pcs 3,4
        do_reset();
        for (int i = 0; i < 3; i++) push(32'(i));
        out_ready = 1'b1;
        start = 1'b1;
        step(1);
        start = 1'b0;
        step(4);
        out_ready = 1'b0;
        step(2);
        chk("rd_pre_pc", out_pc, 32'd3);
        chk("rd_pre_addr", imem_addr, 32'd5);
        redirect = 1'b1;
        redirect_pc = 32'd7;
        step(1);
        redirect = 1'b0;
        chk("rd_flush_valid", 32'(out_valid), 32'd0);
        chk("rd_addr", imem_addr, 32'd7);
        push(32'd7);
        push(32'd8);
        out_ready = 1'b1;
        step(3);
        out_ready = 1'b0;
        chk("rd_q_empty", 32'(exp_pc_q.size()), 32'd0);

        // Halt at pc=5 with 2 buffered, drain, then resume
        do_reset();
        for (int i = 0; i < 3; i++) push(32'(i));
        out_ready = 1'b1;
        start = 1'b1;
        step(1);
        start = 1'b0;
        step(4);
        out_ready = 1'b0;
        step(2);
        chk("halt_pre_addr", imem_addr, 32'd5);
        push(32'd3);
        push(32'd4);
        halt = 1'b1;
        out_ready = 1'b1;
        step(1);
        halt = 1'b0;
        step(1);
        chk("halt_drained", 32'(out_valid), 32'd0);
        chk("halt_state", 32'(state_o), 32'(HALTED));
        chk("halt_addr", imem_addr, 32'd5);
        halt = 1'b1;
        start = 1'b1;
        step(1);
        chk("halt_beats_start", 32'(state_o), 32'(HALTED));
        halt = 1'b0;
        start = 1'b0;
        step(1);
        chk("halt_addr_hold", imem_addr, 32'd5);
        push(32'd5);
        push(32'd6);
        start = 1'b1;
        step(1);
        start = 1'b0;
        step(3);
        out_ready = 1'b0;
        chk("halt_q_empty", 32'(exp_pc_q.size()), 32'd0);

        // Jump at pc 18
        push(32'd17);
        push(32'd18);
`ifdef INST_FETCH_PREDECODE_EN
        push(32'd7);
        push(32'd8);
`else
        push(32'd19);
        push(32'd20);
`endif
        redirect_run(32'd17);

        // PC wrap at IMEM_DEPTH-1
        push(32'd1022);
        push(32'd1023);
        push(32'd0);
        push(32'd1);
        redirect_run(32'd1022);

        // Asynchronous reset with a full buffer
        do_reset();
        start = 1'b1;
        step(1);
        start = 1'b0;
        step(3);
        chk("ar_pre_valid", 32'(out_valid), 32'd1);
        chk("ar_pre_addr", imem_addr, 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_valid", 32'(out_valid), 32'd0);
        chk("ar_state", 32'(state_o), 32'(IDLE));
        chk("ar_addr", imem_addr, 32'd0);
        chk("ar_pc", out_pc, 32'd0);
        step(1);
        rst_n = 1'b1;
        step(2);
        chk("final_q_empty", 32'(exp_pc_q.size()), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
